rect_draw_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the rectangle rasteriser. It accepts rectangle draw commands (origin, size, colour), buffers them in a small FIFO, and feeds them to the rasteriser one at a time. It gates the rasteriser's enable for exactly width×height cycles and produces the `plot`/`colour` strobe for the VGA adapter, aligned with the rasteriser's pixel coordinates.

---
 rtl/draw_pkg.sv | 26 ++
 rtl/rect_cmd_fifo.sv | 61 ++++++
 rtl/rect_draw_sequencer.sv | 150 +++++++++++++++
 tb/tb_rect_draw_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared geometry constants, the queued command format and the sequencer state encoding.
package draw_pkg;

  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int AREA_W       = X_W + Y_W;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  // Widest colour a queued command can carry; the sequencer's COLOUR_W must not exceed it.
  localparam int MAX_COLOUR_W = 8;

  typedef struct packed {
    logic [X_W-1:0]          x;
    logic [Y_W-1:0]          y;
    logic [X_W-1:0]          w;
    logic [Y_W-1:0]          h;
    logic [MAX_COLOUR_W-1:0] colour;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAW
  } state_e;

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous command FIFO with a combinational head.
// A push is refused while full, even if a pop happens in the same cycle.
module rect_cmd_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       push_i,
  input  rect_cmd_t  push_dat_i,
  input  logic       pop_i,
  output rect_cmd_t  pop_dat_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [DEPTH:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  rect_cmd_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign full_o    = (count_q == (DEPTH+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (DEPTH+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (DEPTH+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/rect_draw_sequencer.sv
// Queues rectangle commands and gates the rasteriser for exactly w*h plot cycles per command.
// Optional screen clipping when RECT_CLIP_EN is defined; cmd_ready is low only while the FIFO is full.
module rect_draw_sequencer
  import draw_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x,
  input  logic [Y_W-1:0]      cmd_y,
  input  logic [X_W-1:0]      cmd_w,
  input  logic [Y_W-1:0]      cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic                rd_enable,
  output logic [X_W-1:0]      rd_x,
  output logic [Y_W-1:0]      rd_y,
  output logic [X_W-1:0]      rd_width,
  output logic [Y_W-1:0]      rd_height,
  output logic                plot,
  output logic [COLOUR_W-1:0] colour,
  output logic                busy
);

  rect_cmd_t           push_cmd, head;
  logic                fifo_full, fifo_empty, pop, push_fire, pop_fire, more_after;
  logic [DEPTH:0]      fifo_count;
  state_e              state_q, state_d;
  logic [AREA_W-1:0]   remaining_q, remaining_d, area;
  logic [X_W-1:0]      rd_x_q, rd_x_d, rd_width_q, rd_width_d, eff_w;
  logic [Y_W-1:0]      rd_y_q, rd_y_d, rd_height_q, rd_height_d, eff_h;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                offscreen, discard, unused_colour;

  always_comb begin
    push_cmd        = '0;
    push_cmd.x      = cmd_x;
    push_cmd.y      = cmd_y;
    push_cmd.w      = cmd_w;
    push_cmd.h      = cmd_h;
    push_cmd.colour = MAX_COLOUR_W'(cmd_colour);
  end

  rect_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push_i     (cmd_valid),
    .push_dat_i (push_cmd),
    .pop_i      (pop),
    .pop_dat_o  (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign unused_colour = ^head.colour;
  assign pop        = (state_q == ST_LOAD);
  assign push_fire  = cmd_valid && !fifo_full;
  assign pop_fire   = pop && !fifo_empty;
  // FIFO still holds a command once this cycle's push and pop have landed.
  assign more_after = push_fire || (fifo_count > (DEPTH+1)'(pop_fire));

`ifdef RECT_CLIP_EN
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;

  always_comb begin
    x_end     = {1'b0, head.x} + {1'b0, head.w};
    y_end     = {1'b0, head.y} + {1'b0, head.h};
    offscreen = (head.x >= X_W'(SCREEN_W)) || (head.y >= Y_W'(SCREEN_H));
    eff_w     = head.w;
    eff_h     = head.h;
    if (x_end > (X_W+1)'(SCREEN_W)) eff_w = X_W'((X_W+1)'(SCREEN_W) - {1'b0, head.x});
    if (y_end > (Y_W+1)'(SCREEN_H)) eff_h = Y_W'((Y_W+1)'(SCREEN_H) - {1'b0, head.y});
    if (offscreen) begin
      eff_w = '0;
      eff_h = '0;
    end
  end
`else
  assign eff_w     = head.w;
  assign eff_h     = head.h;
  assign offscreen = 1'b0;
`endif

  assign area    = AREA_W'(eff_w) * AREA_W'(eff_h);
  assign discard = offscreen || (area == '0);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rd_x_d      = rd_x_q;
    rd_y_d      = rd_y_q;
    rd_width_d  = rd_width_q;
    rd_height_d = rd_height_q;
    colour_d    = colour_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        rd_x_d      = head.x;
        rd_y_d      = head.y;
        rd_width_d  = eff_w;
        rd_height_d = eff_h;
        colour_d    = COLOUR_W'(head.colour);
        remaining_d = area;
        if (discard) state_d = more_after ? ST_LOAD : ST_IDLE;
        else         state_d = ST_DRAW;
      end
      ST_DRAW: begin
        remaining_d = remaining_q - AREA_W'(1);
        if (remaining_q == AREA_W'(1)) state_d = more_after ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      rd_width_q  <= '0;
      rd_height_q <= '0;
      colour_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      rd_width_q  <= rd_width_d;
      rd_height_q <= rd_height_d;
      colour_q    <= colour_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign rd_enable = (state_q == ST_DRAW);
  assign plot      = (state_q == ST_DRAW);
  assign rd_x      = rd_x_q;
  assign rd_y      = rd_y_q;
  assign rd_width  = rd_width_q;
  assign rd_height = rd_height_q;
  assign colour    = colour_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_rect_draw_sequencer.sv
// Directed bench for rect_draw_sequencer; expected clipped counts depend on RECT_CLIP_EN.
module tb_rect_draw_sequencer;

  logic       clock = 1'b0;
  logic       resetn, cmd_valid, cmd_ready;
  logic [9:0] cmd_x, cmd_w, rd_x, rd_width;
  logic [8:0] cmd_y, cmd_h, rd_y, rd_height;
  logic [2:0] cmd_colour, colour;
  logic       rd_enable, plot, busy;

  rect_draw_sequencer #(.DEPTH(4), .COLOUR_W(3)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_colour (cmd_colour),
    .rd_enable  (rd_enable),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_width   (rd_width),
    .rd_height  (rd_height),
    .plot       (plot),
    .colour     (colour),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int cyc = 0, plots = 0, bursts = 0, first_plot = -1, last_plot = -1, attr_bad = 0;
  logic prev_plot = 1'b0;
  logic attr_en   = 1'b0;
  logic [9:0] exp_x = '0;
  logic [8:0] exp_y = '0;
  logic [2:0] exp_c = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance to the next falling edge and fold the plot strobe into the running stats.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (plot === 1'b1) begin
      plots++;
      if (first_plot < 0) first_plot = cyc;
      last_plot = cyc;
      if (!prev_plot) bursts++;
      if (attr_en && (rd_x !== exp_x || rd_y !== exp_y || colour !== exp_c)) attr_bad++;
    end
    prev_plot = plot;
  endtask

  task automatic clear_stats();
    plots = 0; bursts = 0; first_plot = -1; last_plot = -1; attr_bad = 0;
  endtask

  task automatic push(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                      input logic [8:0] h, input logic [2:0] c, output int waited);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_colour = c;
    cmd_valid = 1'b1;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (cmd_ready !== 1'b1) check("push_accept", 32'(cmd_ready), 1);
    else tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) check("drain_timeout", 32'(busy), 0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, acc, wsum;
    resetn = 1'b0; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;
    repeat (3) tick();
    check("reset_ready",  32'(cmd_ready), 1);
    check("reset_plot",   32'(plot), 0);
    check("reset_enable", 32'(rd_enable), 0);
    check("reset_busy",   32'(busy), 0);
    check("reset_rd_x",   32'(rd_x), 0);
    check("reset_rd_y",   32'(rd_y), 0);
    check("reset_width",  32'(rd_width), 0);
    check("reset_height", 32'(rd_height), 0);
    check("reset_colour", 32'(colour), 0);
    resetn = 1'b1;
    tick();

    // Single 3x2 rectangle.
    clear_stats();
    attr_en = 1'b1; exp_x = 10'd10; exp_y = 9'd20; exp_c = 3'd4;
    push(10'd10, 9'd20, 10'd3, 9'd2, 3'd4, w);
    acc = cyc;
    wait_idle(50);
    attr_en = 1'b0;
    check("t1_plots",   32'(plots), 6);
    check("t1_latency", 32'(first_plot - acc), 2);
    check("t1_bursts",  32'(bursts), 1);
    check("t1_span",    32'(last_plot - first_plot), 5);
    check("t1_attr",    32'(attr_bad), 0);
    check("t1_width",   32'(rd_width), 3);
    check("t1_height",  32'(rd_height), 2);
    check("t1_busy",    32'(busy), 0);
    check("t1_enable",  32'(rd_enable), 0);

    // One 4x2 rectangle keeps the FIFO draining slowly while five 1x1 commands arrive.
    clear_stats();
    wsum = 0;
    push(10'd100, 9'd50, 10'd4, 9'd2, 3'd1, w);
    wsum += w;
    for (int i = 1; i <= 4; i++) begin
      push(10'(i), 9'(i), 10'd1, 9'd1, 3'(i + 1), w);
      wsum += w;
    end
    check("t2_nowait", 32'(wsum), 0);
    check("t2_full_ready", 32'(cmd_ready), 0);
    push(10'd5, 9'd5, 10'd1, 9'd1, 3'd6, w);
    check("t2_c5_wait", 32'(w), 7);
    wait_idle(100);
    check("t2_plots",  32'(plots), 13);
    check("t2_bursts", 32'(bursts), 6);
    check("t2_span",   32'(last_plot - first_plot), 17);
    check("t2_rd_x",   32'(rd_x), 5);
    check("t2_colour", 32'(colour), 6);

    // Zero-area command sandwiched between two 2x2 rectangles.
    clear_stats();
    push(10'd0, 9'd0, 10'd2, 9'd2, 3'd3, w);
    push(10'd0, 9'd0, 10'd0, 9'd7, 3'd2, w);
    push(10'd40, 9'd30, 10'd2, 9'd2, 3'd5, w);
    wait_idle(100);
    check("t3_plots",  32'(plots), 8);
    check("t3_bursts", 32'(bursts), 2);
    check("t3_span",   32'(last_plot - first_plot), 9);
    check("t3_rd_x",   32'(rd_x), 40);
    check("t3_width",  32'(rd_width), 2);
    check("t3_colour", 32'(colour), 5);

    // Reset during a 4x4 draw with another command queued.
    push(10'd200, 9'd100, 10'd4, 9'd4, 3'd7, w);
    push(10'd1, 9'd1, 10'd1, 9'd1, 3'd1, w);
    tick();
    tick();
    check("t4_pre_plot", 32'(plot), 1);
    resetn = 1'b0;
    tick();
    check("t4_plot",   32'(plot), 0);
    check("t4_enable", 32'(rd_enable), 0);
    check("t4_ready",  32'(cmd_ready), 1);
    check("t4_busy",   32'(busy), 0);
    check("t4_rd_x",   32'(rd_x), 0);
    resetn = 1'b1;
    clear_stats();
    repeat (30) tick();
    check("t4_flushed", 32'(plots), 0);

    // Rectangle crossing the bottom-right screen corner, then one fully off-screen.
    clear_stats();
    push(10'd630, 9'd470, 10'd20, 9'd20, 3'd2, w);
    wait_idle(1000);
    check("t5_bursts", 32'(bursts), 1);
`ifdef RECT_CLIP_EN
    check("t5_plots",  32'(plots), 100);
    check("t5_width",  32'(rd_width), 10);
    check("t5_height", 32'(rd_height), 10);
`else
    check("t5_plots",  32'(plots), 400);
    check("t5_width",  32'(rd_width), 20);
    check("t5_height", 32'(rd_height), 20);
`endif
    clear_stats();
    push(10'd700, 9'd10, 10'd1, 9'd1, 3'd1, w);
    wait_idle(50);
`ifdef RECT_CLIP_EN
    check("t6_plots", 32'(plots), 0);
`else
    check("t6_plots", 32'(plots), 1);
`endif
    check("t6_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
